// File: rtl/reverse_skew_buffer.sv
// rtl/reverse_skew_buffer.sv - de-skews the diagonal output stream of an NxN systolic array
// Captures 2N-1 skewed write beats into an NxN matrix, then plays it out one aligned row per read.
module reverse_skew_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ARRAY_SIZE = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         write,
   input  logic                         read,
   input  logic signed [DATA_WIDTH-1:0] data_in  [ARRAY_SIZE],
   output logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE]
);

   localparam int CW = $clog2(2*ARRAY_SIZE-1);
   localparam int PW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [CW-1:0] WR_LAST = CW'(2*ARRAY_SIZE-2);
   localparam logic [PW-1:0] RD_LAST = PW'(ARRAY_SIZE-1);

   logic signed [DATA_WIDTH-1:0] mem [ARRAY_SIZE][ARRAY_SIZE];
   logic [CW-1:0] wr_cnt;
   logic [PW-1:0] rd_ptr;
   logic          wr_accept;

   assign wr_accept = write & enable;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt <= '0;
      end else if (wr_accept) begin
         wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + 1'b1;
      end
   end

   // Element (r,j) sits on anti-diagonal r+j, so it is captured on exactly that beat.
   for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
      for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
         localparam logic [CW-1:0] DIAG = CW'(r + j);
         always_ff @(posedge clk) begin
            if (rst) begin
               mem[r][j] <= '0;
            end else if (wr_accept && wr_cnt == DIAG) begin
               mem[r][j] <= data_in[j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         for (int j = 0; j < ARRAY_SIZE; j++) begin
            data_out[j] <= '0;
         end
      end else if (read) begin
         rd_ptr <= (rd_ptr == RD_LAST) ? '0 : rd_ptr + 1'b1;
         for (int j = 0; j < ARRAY_SIZE; j++) begin
            data_out[j] <= mem[rd_ptr][j];
         end
      end
   end

endmodule

// File: tb/tb_reverse_skew_buffer.sv
// tb/tb_reverse_skew_buffer.sv - table-driven bench for reverse_skew_buffer (N=4, 32-bit)
module tb_reverse_skew_buffer;

    localparam int DW = 32;
    localparam int N  = 4;

    typedef logic [N-1:0][DW-1:0] vec_t;

    typedef struct {
        logic rst;
        logic en;
        logic wr;
        logic rd;
        vec_t din;
        logic chk;
        vec_t exp;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic write = 1'b0;
    logic read = 1'b0;
    logic signed [DW-1:0] data_in  [N];
    logic signed [DW-1:0] data_out [N];

    vector_t vecs [$];
    int n_vec = 0;
    int n_bad = 0;

    reverse_skew_buffer #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .write(write), .read(read),
        .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL: timeout waiting for the vector table to complete");
        $finish;
    end

    function automatic vec_t row4(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic vec_t fill(input logic [DW-1:0] x);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = x;
        return v;
    endfunction

    function automatic logic [DW-1:0] val(input int kind, input int t, input int j);
        case (kind)
            0:       return DW'(t + 1);
            1:       return DW'(1000 + 16*t + j);
            2:       return DW'(-(5 + 16*t + j));
            3:       return DW'(200 + 16*t + j);
            default: return DW'(32'h0BAD_0000 + t);
        endcase
    endfunction

    function automatic vec_t beat_din(input int kind, input int t);
        vec_t v;
        for (int j = 0; j < N; j++)
            v[j] = (t - j >= 0 && t - j <= N-1) ? val(kind, t, j) : 32'h7FFF_FFFF;
        return v;
    endfunction

    function automatic vec_t tile_row(input int kind, input int r);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = val(kind, r + j, j);
        return v;
    endfunction

    task automatic add(input logic r, input logic e, input logic w, input logic rd,
                       input vec_t din, input logic chk, input vec_t ex);
        vector_t v;
        v.rst = r; v.en = e; v.wr = w; v.rd = rd; v.din = din; v.chk = chk; v.exp = ex;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t z;
        vec_t junk;
        z    = fill('0);
        junk = fill(32'hDEAD_BEEF);
        for (int j = 0; j < N; j++) data_in[j] = '0;

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (data_out[j] !== '0) begin
                $display("FAIL reset: lane%0d data_out=%h expected 0", j, data_out[j]);
                n_bad++;
            end
        end

        add(1, 0, 0, 0, z, 1, z);
        add(0, 0, 0, 1, z, 1, z);
        add(1, 0, 0, 0, z, 1, z);

        for (int t = 0; t < 2*N-1; t++) add(0, 1, 1, 0, beat_din(0, t), 1, z);
        add(0, 0, 0, 1, z, 1, row4(1, 2, 3, 4));
        add(0, 0, 0, 1, z, 1, row4(2, 3, 4, 5));
        add(0, 0, 0, 1, z, 1, row4(3, 4, 5, 6));
        add(0, 0, 0, 1, z, 1, row4(4, 5, 6, 7));

        add(0, 0, 0, 0, z, 1, row4(4, 5, 6, 7));
        add(0, 1, 0, 0, junk, 1, row4(4, 5, 6, 7));
        add(0, 0, 0, 1, z, 1, row4(1, 2, 3, 4));
        add(0, 0, 0, 1, z, 1, row4(2, 3, 4, 5));
        add(0, 0, 0, 1, z, 1, row4(3, 4, 5, 6));
        add(0, 0, 0, 1, z, 1, row4(4, 5, 6, 7));

        add(0, 1, 1, 1, beat_din(1, 0), 1, row4(1, 2, 3, 4));
        for (int t = 1; t <= 3; t++) add(0, 1, 1, 0, beat_din(1, t), 1, row4(1, 2, 3, 4));
        add(0, 0, 1, 0, junk, 1, row4(1, 2, 3, 4));
        add(0, 0, 1, 0, fill(32'h7FFF_FFFF), 1, row4(1, 2, 3, 4));
        for (int t = 4; t < 2*N-1; t++) add(0, 1, 1, 0, beat_din(1, t), 0, z);
        for (int r = 1; r <= N; r++) add(0, 0, 0, 1, z, 1, tile_row(1, r % N));

        for (int t = 0; t < 2*N-1; t++) add(0, 1, 1, 0, beat_din(2, t), 0, z);
        add(0, 0, 0, 1, z, 1, row4(-21, -38, -55, -72));
        for (int r = 2; r <= N; r++) add(0, 0, 0, 1, z, 1, tile_row(2, r % N));

        for (int t = 0; t < 4; t++) add(0, 1, 1, 0, beat_din(4, t), 0, z);
        add(1, 1, 1, 1, beat_din(4, 4), 1, z);
        for (int t = 0; t < 2*N-1; t++) add(0, 1, 1, 0, beat_din(3, t), 1, z);
        add(0, 0, 0, 1, z, 1, row4(200, 217, 234, 251));
        for (int r = 1; r < N; r++) add(0, 0, 0, 1, z, 1, tile_row(3, r));

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            enable = vecs[i].en;
            write  = vecs[i].wr;
            read   = vecs[i].rd;
            for (int j = 0; j < N; j++) data_in[j] = vecs[i].din[j];
            @(posedge clk);
            #1;
            if (vecs[i].chk) begin
                logic bad;
                bad = 1'b0;
                n_vec++;
                for (int j = 0; j < N; j++) begin
                    if (data_out[j] !== vecs[i].exp[j]) begin
                        $display("FAIL vec%0d lane%0d: data_out=%h expected=%h",
                                 i, j, data_out[j], vecs[i].exp[j]);
                        bad = 1'b1;
                    end
                end
                if (bad) n_bad++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else            $display("PASS");
        $finish;
    end

endmodule

// File: doc/reverse_skew_buffer.md
Name: reverse_skew_buffer

Overview:
- De-skew buffer on the output side of an ARRAY_SIZE x ARRAY_SIZE systolic matrix multiplier.
- Captures the diagonally skewed result stream from the array's output lanes over 2*ARRAY_SIZE-1 write cycles and reassembles it into an aligned result matrix.
- Then plays the matrix out one full row per read cycle, all lanes aligned.

Parameters:
- DATA_WIDTH, 32: signed width of each accumulated result element.
- ARRAY_SIZE, 4: systolic array dimension N; number of lanes and number of stored rows. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  write qualifier; a write beat is accepted only when enable=1 and write=1.
- write  input  1  write request; one skewed slice per accepted beat.
- read  input  1  read request; one aligned row per cycle. Independent of enable.
- data_in  input  signed [DATA_WIDTH-1:0] x ARRAY_SIZE (unpacked array)  skewed lane data; lane j comes from array column j.
- data_out  output  signed [DATA_WIDTH-1:0] x ARRAY_SIZE (unpacked array)  aligned row output, registered.

Behaviour:
- Storage: mem[r][j], r,j in 0..N-1, each element DATA_WIDTH bits.
- Write counter wr_cnt, range 0..2N-2, $clog2(2N-1) bits. Read pointer rd_ptr, range 0..N-1.
- Reset (rst=1 at clk edge): wr_cnt=0, rd_ptr=0, every mem element=0, every data_out lane=0. Reset overrides write and read in the same cycle and may be applied mid-operation.
- Accepted write beat (write & enable), with t = wr_cnt, for every lane j:
  - if 0 <= t-j <= N-1: mem[t-j][j] <= data_in[j];
  - otherwise lane j is ignored (its data is not yet valid, or already finished).
- Consequence: lane j contributes on beats j..j+N-1; beat 0 writes only lane 0; beat 2N-2 writes only lane N-1.
- wr_cnt increments per accepted beat. After beat 2N-2 it wraps to 0, ready for the next tile.
- write=1 with enable=0: no mem change, wr_cnt holds (stall). write=0: no change regardless of enable.
- Read (read=1), registered, latency 1: at the edge, data_out[j] <= mem[rd_ptr][j] for all j, and rd_ptr increments, wrapping N-1 -> 0.
- read=0: data_out holds its last value and rd_ptr holds.
- Simultaneous accepted write and read: read returns mem contents from before this edge's write. Both pointers advance independently.
- No arithmetic is performed; data passes through bit-exact, signed.
- No overflow or underflow flags. Reading before a tile completes returns partially written or stale contents. That is legal; the controller must sequence write and read correctly.

Test Plan:
- Reset: assert rst 1 cycle with write=read=0 -> all data_out lanes 0; a subsequent read of any row returns 0s.
- Full tile, N=4: enable=write=1 for 7 beats, data_in[j]=t+1 on beat t; then read=1 for 4 cycles.
  - Required output rows, one per cycle: {1,2,3,4}, {2,3,4,5}, {3,4,5,6}, {4,5,6,7}.
  - Generally mem[r][j] = r+j+1.
- Read hold: after the 4 reads, drop read -> data_out stays {4,5,6,7}. Assert read again -> wraps to row 0 = {1,2,3,4}.
- Write stall: hold enable=0 with write=1 for 2 cycles between beats 3 and 4 -> final matrix identical to the unstalled case. Changing data_in during the stall has no effect.
- Lane gating: drive 0x7FFFFFFF on lanes where t-j is out of range (e.g. lanes 1..3 on beat 0, lanes 0..2 on beat 6) and valid values elsewhere -> 0x7FFFFFFF never appears in the read-out rows.
- Signed pass-through and mid-op reset:
  - Write a tile containing negative values (e.g. -5) -> read back bit-exact.
  - Assert rst after beat 3 of a tile, then write a fresh 7-beat tile -> output reflects only the fresh tile, starting from row 0.
